// File: rtl/stream_upsizer_pkg.sv
// rtl/stream_upsizer_pkg.sv - shared stream constants and lane-mask helper
//
// Purpose: defaults shared between the byte FIFO and the stream upsizer,
//          plus the keep-mask helper used when closing a word.
// Ports:   none (package).

package stream_pkg;

   // Beat width; matches the byte FIFO DATA_WIDTH.
   localparam int STREAM_IN_WIDTH = 8;
   // Narrow beats packed into one wide word.
   localparam int STREAM_RATIO    = 4;
   // Widest lane count the keep helper can describe.
   localparam int KEEP_MAX        = 32;

   // Mask with the low 'count' bits set (lanes 0..count-1 filled).
   // Callers size-cast the result down to their own RATIO.
   function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned count);
      logic [KEEP_MAX-1:0] m;
      m = '0;
      for (int i = 0; i < KEEP_MAX; i++) begin
         if (i < count) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - packs RATIO narrow beats into one registered wide word
//
// Purpose: consumes the FIFO dequeue stream and emits one OUT_WIDTH word per
//          RATIO beats, or earlier when in_last closes a partial word.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_valid/in_ready    narrow beat handshake (in_ready drives FIFO deq_ready)
//   in_data, in_last     beat payload and word/frame close flag
//   out_valid/out_ready  wide word handshake
//   out_data             packed word, first beat in lane 0 (LSBs)
//   out_keep, out_last   filled-lane mask, word closed by in_last

module stream_upsizer
   import stream_pkg::*;
#(
   parameter int IN_WIDTH = STREAM_IN_WIDTH,
   parameter int RATIO    = STREAM_RATIO
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [IN_WIDTH-1:0]       in_data,
   input  logic                      in_last,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [IN_WIDTH*RATIO-1:0] out_data,
   output logic [RATIO-1:0]          out_keep,
   output logic                      out_last,
   input  logic                      out_ready
);

   localparam int OUT_WIDTH = IN_WIDTH * RATIO;
   localparam int CNT_W     = $clog2(RATIO);

   logic [OUT_WIDTH-1:0] acc_data;
   logic [CNT_W-1:0]     acc_cnt;

   logic                 accept;
   logic                 complete;
   logic [OUT_WIDTH-1:0] merged;
   logic [RATIO-1:0]     fill_keep;

   // Input may advance whenever the output register is empty or draining
   // this cycle; stalling partial beats too keeps the control trivial.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign complete = accept && (in_last || (acc_cnt == CNT_W'(RATIO - 1)));

   // Lanes above acc_cnt are still zero in the accumulator, so a word
   // closed early carries zeros in its unfilled lanes.
   always_comb begin
      merged = acc_data;
      for (int i = 0; i < RATIO; i++) begin
         if (acc_cnt == CNT_W'(i)) merged[i*IN_WIDTH +: IN_WIDTH] = in_data;
      end
   end

   // Keep depends only on the count, so unknown data never reaches it.
   assign fill_keep = RATIO'(keep_mask(int'(acc_cnt) + 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_data  <= '0;
         acc_cnt   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;

         if (complete) begin
            // Overrides the drain above: back-to-back words without a bubble.
            out_valid <= 1'b1;
            out_data  <= merged;
            out_keep  <= fill_keep;
            out_last  <= in_last;
            acc_data  <= '0;
            acc_cnt   <= '0;
         end else if (accept) begin
            acc_data  <= merged;
            acc_cnt   <= acc_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_stream_upsizer.sv
// tb/tb_stream_upsizer.sv - self-checking bench for stream_upsizer

module tb_stream_upsizer;

   localparam int IW = 8;
   localparam int R  = 4;
   localparam int OW = IW * R;

   typedef struct {
      logic [OW-1:0] d;
      logic [R-1:0]  k;
      logic          l;
   } word_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [IW-1:0] in_data;
   logic          in_last;
   logic          in_ready;
   logic          out_valid;
   logic [OW-1:0] out_data;
   logic [R-1:0]  out_keep;
   logic          out_last;
   logic          out_ready;

   int total = 0;
   int bad   = 0;

   word_t         exp_q[$];
   logic [IW-1:0] acc_b[$];
   int            words_seen;
   int            valid_cycles;
   logic          prev_stall;
   logic [OW-1:0] prev_d;
   logic [R-1:0]  prev_k;
   logic          prev_l;

   always #5 clk = ~clk;

   stream_upsizer #(.IN_WIDTH(IW), .RATIO(R)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
      .out_last(out_last), .out_ready(out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: collect accepted bytes; a word closes after R bytes or on last.
   task automatic model_accept(input logic [IW-1:0] d, input logic l);
      word_t w;
      acc_b.push_back(d);
      if (l || acc_b.size() == R) begin
         w.d = '0;
         for (int i = 0; i < acc_b.size(); i++) w.d = w.d | (OW'(acc_b[i]) << (IW * i));
         w.k = R'((1 << acc_b.size()) - 1);
         w.l = l;
         exp_q.push_back(w);
         acc_b.delete();
      end
   endtask

   task automatic cycle(input logic v, input logic [IW-1:0] d, input logic l, input logic r);
      word_t w;
      in_valid = v; in_data = d; in_last = l; out_ready = r;
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || r));
      if (prev_stall) begin
         chk("hold_data", out_data, prev_d);
         chk("hold_keep", 32'(out_keep), 32'(prev_k));
         chk("hold_last", 32'(out_last), 32'(prev_l));
      end
      prev_stall = out_valid && !r;
      prev_d = out_data; prev_k = out_keep; prev_l = out_last;
      if (out_valid) valid_cycles++;
      if (out_valid && r && exp_q.size() != 0) begin
         w = exp_q.pop_front();
         chk("word_data", out_data, w.d);
         chk("word_keep", 32'(out_keep), 32'(w.k));
         chk("word_last", 32'(out_last), 32'(w.l));
         words_seen++;
      end
      if (v && in_ready) model_accept(d, l);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out_keep", 32'(out_keep), 32'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      acc_b.delete();
      prev_stall = 1'b0;
   endtask

   initial begin
      words_seen = 0; valid_cycles = 0; prev_stall = 1'b0;
      do_reset();
      chk("reset_out_data", out_data, 32'h0);
      chk("reset_out_last", 32'(out_last), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      // Full word, exactly one valid cycle.
      valid_cycles = 0;
      cycle(1, 8'h11, 0, 1); cycle(1, 8'h22, 0, 1);
      cycle(1, 8'h33, 0, 1); cycle(1, 8'h44, 0, 1);
      chk("t1_data", out_data, 32'h44332211);
      chk("t1_keep", 32'(out_keep), 32'hf);
      chk("t1_valid", 32'(out_valid), 32'd1);
      repeat (3) cycle(0, 8'h00, 0, 1);
      chk("t1_valid_cycles", valid_cycles, 1);

      // Early close, then a fresh word starting at lane 0.
      cycle(1, 8'haa, 0, 1); cycle(1, 8'hbb, 1, 1);
      chk("t2_data", out_data, 32'h0000bbaa);
      chk("t2_keep", 32'(out_keep), 32'h3);
      chk("t2_last", 32'(out_last), 32'd1);
      cycle(1, 8'h01, 0, 1); cycle(1, 8'h02, 0, 1);
      cycle(1, 8'h03, 0, 1); cycle(1, 8'h04, 0, 1);
      chk("t2b_data", out_data, 32'h04030201);
      chk("t2b_keep", 32'(out_keep), 32'hf);
      chk("t2b_last", 32'(out_last), 32'd0);
      cycle(1, 8'h09, 1, 1);
      chk("t2c_keep", 32'(out_keep), 32'h1);
      chk("t2c_last", 32'(out_last), 32'd1);
      cycle(0, 8'h00, 0, 1);

      // Back-pressure: word held 10 cycles, input stalled, no gap after release.
      cycle(1, 8'h41, 0, 0); cycle(1, 8'h42, 0, 0);
      cycle(1, 8'h43, 0, 0); cycle(1, 8'h44, 0, 0);
      repeat (10) begin
         cycle(1, 8'h50, 0, 0);
         chk("t3_in_ready_low", 32'(in_ready), 32'd0);
      end
      cycle(1, 8'h50, 0, 1); cycle(1, 8'h51, 0, 1);
      cycle(1, 8'h52, 0, 1); cycle(1, 8'h53, 0, 1);
      chk("t3_next_data", out_data, 32'h53525150);
      repeat (2) cycle(0, 8'h00, 0, 1);

      // Streaming at full rate.
      words_seen = 0; valid_cycles = 0;
      for (int i = 0; i < 400; i++) cycle(1, 8'(i), 0, 1);
      repeat (2) cycle(0, 8'h00, 0, 1);
      chk("t4_words", words_seen, 100);
      chk("t4_valid_cycles", valid_cycles, 100);

      // Reset mid-word discards the partial accumulator.
      cycle(1, 8'he1, 0, 1); cycle(1, 8'he2, 0, 1);
      do_reset();
      cycle(1, 8'h05, 0, 1); cycle(1, 8'h06, 0, 1);
      cycle(1, 8'h07, 0, 1); cycle(1, 8'h08, 0, 1);
      chk("t5_data", out_data, 32'h08070605);
      chk("t5_keep", 32'(out_keep), 32'hf);
      cycle(0, 8'h00, 0, 1);

      // Random traffic against the reference model.
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) != 0);
      cycle(0, 8'h00, 0, 1);
      cycle(1, 8'h5a, 1, 1);
      repeat (3) cycle(0, 8'h00, 0, 1);
      chk("t6_queue_empty", exp_q.size(), 0);
      chk("t6_acc_empty", acc_b.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
